n_bit_seq_div: RTL

- Sequential restoring divider; the inverse of the team's array multiplier.
- Operands load over a shared data_in bus into two holding registers. A start pulse launches an N-cycle shift/subtract sequence.
- Registered quotient and remainder are held until the next completion.
- Sits beside the multiplier in the arithmetic datapath and reuses the same operand-load handshake.

---
 rtl/n_bit_seq_div.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/n_bit_seq_div.sv
// Sequential restoring divider: N-cycle shift/subtract over operands loaded from a shared bus.
// Define SIGNED_DIV_EN for two's-complement operands (truncating division, remainder takes dividend sign).
module n_bit_seq_div #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [N-1:0] data_in,
    input  logic         load_a,
    input  logic         load_b,
    input  logic         start,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, ZERO} state_t;

    // Handshake: start is sampled only while busy=0 (IDLE, including the done cycle);
    // done is a one-cycle pulse marking the edge that updated quotient/remainder.
    state_t         state, state_nxt;
    logic [N-1:0]   a_reg, b_reg;
    logic [N-1:0]   a_mag, b_mag;
    logic [N-1:0]   pr, wq, dv;
    logic [CW-1:0]  cnt;
    logic [N:0]     shifted, trial;
    logic [N-1:0]   pr_nxt, wq_nxt;
    logic [N-1:0]   q_fix, r_fix;

`ifdef SIGNED_DIV_EN
    logic a_neg, b_neg, sa, sb;
    assign a_neg = a_reg[N-1];
    assign b_neg = b_reg[N-1];
    assign a_mag = a_neg ? (-a_reg) : a_reg;
    assign b_mag = b_neg ? (-b_reg) : b_reg;
    assign q_fix = (sa ^ sb) ? (-wq_nxt) : wq_nxt;
    assign r_fix = sa ? (-pr_nxt) : pr_nxt;
`else
    assign a_mag = a_reg;
    assign b_mag = b_reg;
    assign q_fix = wq_nxt;
    assign r_fix = pr_nxt;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            if (load_a) a_reg <= data_in;
            if (load_b) b_reg <= data_in;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (b_reg != '0) ? CALC : ZERO;
            CALC: if (cnt == CW'(1)) state_nxt = IDLE;
            ZERO: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
    end

    // One restoring step: shift in the next dividend bit, keep the difference if it did not borrow.
    always_comb begin
        shifted = {pr, wq[N-1]};
        trial   = shifted - {1'b0, dv};
        pr_nxt  = shifted[N-1:0];
        wq_nxt  = {wq[N-2:0], 1'b0};
        if (!trial[N]) begin
            pr_nxt = trial[N-1:0];
            wq_nxt = {wq[N-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pr          <= '0;
            wq          <= '0;
            dv          <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
            sa          <= 1'b0;
            sb          <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b_reg != '0) begin
                            wq  <= a_mag;
                            dv  <= b_mag;
                            pr  <= '0;
                            cnt <= CW'(N);
`ifdef SIGNED_DIV_EN
                            sa  <= a_neg;
                            sb  <= b_neg;
`endif
                        end else begin
                            // Raw dividend kept so the zero-divisor result is immune to later loads.
                            wq <= a_reg;
                        end
                    end
                end
                CALC: begin
                    pr  <= pr_nxt;
                    wq  <= wq_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        quotient    <= q_fix;
                        remainder   <= r_fix;
                        done        <= 1'b1;
                        div_by_zero <= 1'b0;
                    end
                end
                ZERO: begin
                    quotient    <= '1;
                    remainder   <= wq;
                    div_by_zero <= 1'b1;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
